multi_motor_pwm: RTL
====================

Name: multi_motor_pwm

Overview:
- N-channel H-bridge motor PWM generator, parametrised in channel count, counter width, period and dead time.
- Successor to the fixed 4-channel/12-bit motor driver.
- Adds per-period shadowing of duty and drive code (glitch-free updates) and a dead-time interval on forward/reverse reversal.
- Sits between the register file (duty, drive codes, enable) and the motor bridge pins. It also drives the single shared pwm strobe.

Parameters:
- NUM_MOT, 4, number of motor channels (1..8).
- CNT_W, 12, width of the period counter and of each duty value.
- PERIOD, 2601, counter cycles per PWM period (2..2^CNT_W); 2601 gives about 10 kHz at the board clock.
- DEAD_CYCLES, 16, idle cycles inserted at period start after a direction reversal (0 disables; must be < PERIOD).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- mot_en  input  1  global motor enable; gates pwm only
- duty  input  NUM_MOT*CNT_W  per-channel duty; channel i in bits [i*CNT_W +: CNT_W]
- drive_code  input  2*NUM_MOT  per-channel {A,B} code; channel i in bits [2i+1:2i]; A=top, B=bottom
- bemf_sensing  input  1  back-EMF measurement window; forces bridge outputs low
- pwm  output  1  shared PWM strobe
- mtop  output  NUM_MOT  top-side bridge drive per channel
- mbot  output  NUM_MOT  bottom-side bridge drive per channel
- period_start  output  1  one-cycle pulse, coincident with cnt==0 after a wrap

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous and active-high.
- Reset values: cnt=0, duty_sh=0, code_sh=00, dead_cnt=0, pwm=0, mtop=0, mbot=0, period_start=0. Reset mid-period aborts the period; counting restarts at 0 on the first clk edge after rst deasserts.
- Counter: cnt increments by 1 per clk. When cnt==PERIOD-1 it wraps to 0 on the next edge. period_start is registered and goes high in the cycle where cnt==0 following a wrap; it is not asserted on the first period after reset.
- Shadow load: on the edge where cnt wraps PERIOD-1 -> 0, for every channel, duty_sh[i]<=duty[i] and code_sh[i]<=drive_code[i]. Input changes mid-period have no effect until the next wrap.
- Dead time: at the same wrap edge, if the old code_sh[i] and the new drive_code[i] are 10 and 01 (either order), dead_cnt[i]<=DEAD_CYCLES. Otherwise dead_cnt[i] decrements while nonzero. Transitions involving brake (11) or idle (00) load no dead time.
- Channel active condition: act[i] = (cnt < duty_sh[i]) && (dead_cnt[i]==0), unsigned CNT_W-bit compare.
  - duty 0 gives never active.
  - duty >= PERIOD gives active for the whole period.
  - Dead cycles eat into the on-time; they are not appended after it.
- Registered outputs, 1-cycle latency from cnt:
  - mtop_r[i] <= act[i] ? code_sh[i][1] : 0
  - mbot_r[i] <= act[i] ? code_sh[i][0] : 0
  - pwm <= mot_en && |act
- Code meanings: 10 forward, 01 reverse, 11 brake (both sides high while active), 00 idle.
- bemf_sensing: mtop = mtop_r & ~bemf_sensing, and likewise for mbot (combinational, immediate). pwm is not affected by bemf_sensing.
- mot_en low: forces pwm low on the next edge; mtop/mbot are unaffected.
- Simultaneous events:
  - A duty change and a wrap on the same edge: the new duty is captured.
  - A reversal while dead_cnt is still nonzero: dead_cnt reloads to DEAD_CYCLES.

Test Plan:
- Reset: assert rst mid-period with ch0 at duty=1000, code=10. Required: all outputs 0 immediately (asynchronous); after release, cnt restarts at 0 and no output goes high until the first wrap loads the shadows.
- Duty sweep: PERIOD=2601, ch0 code=10, duty set to 0, 1, 1300, 2601 in successive periods. Required: mtop[0] high-cycle counts of 0, 1, 1300 and 2601 per period respectively; mbot[0]=0 throughout; pwm tracks mtop[0] with mot_en=1.
- Shadowing: ch1 code=01, duty changed from 500 to 2000 at cnt=100. Required: that period stays high for 500 cycles; the next period is high for 2000 cycles; no glitch at the change point.
- Dead time: ch2 duty=800; code 10 for one period, then 01. Required: the second period shows mbot[2] low for cnt 0..15 and high for cnt 16..799, and mtop[2]=0. A switch from 10 to 11 inserts no dead time.
- Gating: ch3 code=11, duty=1000. Assert bemf_sensing for cnt 200..299. Required: mtop[3]/mbot[3] low in that same cycle window while pwm stays high. Then mot_en=0: pwm=0 from the next edge while mtop[3]/mbot[3] continue.
- Multi-channel OR: ch0 duty=100 and ch3 duty=400, other channels at duty 0. Required: pwm high for cnt 0..399 (delayed one cycle); period_start pulses once every 2601 cycles.

Source files
------------

// File: rtl/multi_motor_pwm.sv
// multi_motor_pwm: N-channel H-bridge PWM with per-period duty/code shadowing and reversal dead time
module multi_motor_pwm #(
  parameter int NUM_MOT     = 4,
  parameter int CNT_W       = 12,
  parameter int PERIOD      = 2601,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mot_en,
  input  logic [NUM_MOT*CNT_W-1:0] duty,
  input  logic [2*NUM_MOT-1:0]     drive_code,
  input  logic                     bemf_sensing,
  output logic                     pwm,
  output logic [NUM_MOT-1:0]       mtop,
  output logic [NUM_MOT-1:0]       mbot,
  output logic                     period_start
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  logic [CNT_W-1:0] cnt;
  logic wrap;
  logic [NUM_MOT-1:0] act, top_c, bot_c, mtop_r, mbot_r;
  assign wrap = cnt == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      period_start <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + ONE;
      period_start <= wrap;
    end
  for (genvar i = 0; i < NUM_MOT; i++) begin : g_ch
    logic [CNT_W-1:0] duty_sh, dead_cnt;
    logic [1:0] code_sh, code_nx;
    logic rev;
    assign code_nx = drive_code[2*i +: 2];
    assign rev = (code_sh ^ code_nx) == 2'b11 && code_sh[1] != code_sh[0];
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        duty_sh <= '0;
        code_sh <= 2'b00;
        dead_cnt <= '0;
      end else begin
        if (wrap) begin
          duty_sh <= duty[i*CNT_W +: CNT_W];
          code_sh <= code_nx;
        end
        dead_cnt <= wrap && rev ? DEAD : (dead_cnt == '0 ? '0 : dead_cnt - ONE);
      end
    assign act[i] = cnt < duty_sh && dead_cnt == '0;
    assign top_c[i] = code_sh[1];
    assign bot_c[i] = code_sh[0];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mtop_r <= '0;
      mbot_r <= '0;
      pwm <= 1'b0;
    end else begin
      mtop_r <= act & top_c;
      mbot_r <= act & bot_c;
      pwm <= mot_en && |act;
    end
  assign mtop = mtop_r & ~{NUM_MOT{bemf_sensing}};
  assign mbot = mbot_r & ~{NUM_MOT{bemf_sensing}};
endmodule
